// File: rtl/barrett_pkg.sv
// barrett_pkg: shared constants and constant functions for the Barrett reduction pipeline.
package barrett_pkg;
   localparam int DEF_Q = 211;
   localparam int DEF_TAG_W = 4;
   function automatic int calc_k(input int q);
      return $clog2(q);
   endfunction
   function automatic longint calc_mu(input int q);
      return (64'd1 << (2 * calc_k(q))) / q;
   endfunction
endpackage

// File: rtl/barrett_csub.sv
// barrett_csub: conditional subtraction of the modulus, x >= Q ? x - Q : x.
module barrett_csub #(
   parameter int W = 8,
   parameter int Q = 211
) (
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);
   assign y = (x >= W'(Q)) ? x - W'(Q) : x;
endmodule

// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe: three-stage Barrett reduction a mod Q with valid/ready
// handshake, sideband tag and a global stall.
module barrett_reduce_pipe
   import barrett_pkg::*;
#(
   parameter int Q = DEF_Q,
   parameter int K = calc_k(Q),
   parameter int TAG_W = DEF_TAG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2*K-2:0]    in_data,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [K-1:0]      out_data,
   output logic [TAG_W-1:0]  out_tag
);
   localparam int IN_W = 2 * K - 1;
   localparam int P_W = 2 * K;
   localparam logic [K:0] MU = (K + 1)'(calc_mu(Q));

   logic en;
   logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [IN_W-1:0] a1_q, a1_d, r2_q, r2_d;
   logic [P_W-1:0] p1_q, p1_d, t2;
   logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
   logic [K-1:0] d3_q, d3_d;
   logic [IN_W-1:0] c1, c2;

   barrett_csub #(.W(IN_W), .Q(Q)) u_csub0 (.x(r2_q), .y(c1));
   barrett_csub #(.W(IN_W), .Q(Q)) u_csub1 (.x(c1), .y(c2));

   always_comb begin
      en = !(v3_q && !out_ready);
      t2 = p1_q >> K;
      v1_d = en ? in_valid : v1_q;
      a1_d = en ? in_data : a1_q;
      p1_d = en ? P_W'(in_data >> K) * P_W'(MU) : p1_q;
      tag1_d = en ? in_tag : tag1_q;
      // t*Q never exceeds a, so the product fits in IN_W bits
      v2_d = en ? v1_q : v2_q;
      r2_d = en ? a1_q - IN_W'(t2 * P_W'(Q)) : r2_q;
      tag2_d = en ? tag1_q : tag2_q;
      v3_d = en ? v2_q : v3_q;
      d3_d = en ? K'(c2) : d3_q;
      tag3_d = en ? tag2_q : tag3_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         a1_q <= '0;
         p1_q <= '0;
         r2_q <= '0;
         d3_q <= '0;
         tag1_q <= '0;
         tag2_q <= '0;
         tag3_q <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
         a1_q <= a1_d;
         p1_q <= p1_d;
         r2_q <= r2_d;
         d3_q <= d3_d;
         tag1_q <= tag1_d;
         tag2_q <= tag2_d;
         tag3_q <= tag3_d;
      end
   end

   assign in_ready = en;
   assign out_valid = v3_q;
   assign out_data = d3_q;
   assign out_tag = tag3_q;
endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// tb_barrett_reduce_pipe: scoreboard bench driving a Q=211 and a Q=3329 instance in lockstep.
module tb_barrett_reduce_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic [3:0] in_tag = '0;
   logic [14:0] d1 = '0;
   logic [22:0] d2 = '0;
   logic rdy1, rdy2, ov1, ov2;
   logic [7:0] od1;
   logic [11:0] od2;
   logic [3:0] ot1, ot2;
   int checks = 0;
   int errors = 0;
   logic [31:0] q1[$];
   logic [31:0] q2[$];
   bit rand_ready = 1'b0;
   bit held = 1'b0;
   logic [31:0] hold1, hold2;

   always #5 clk = ~clk;

   barrett_reduce_pipe #(.Q(211)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(d1),
      .in_tag(in_tag), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_tag(ot1)
   );
   barrett_reduce_pipe #(.Q(3329)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(d2),
      .in_tag(in_tag), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_tag(ot2)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step(input bit v, input logic [14:0] a, input logic [22:0] b,
                       input int e1, input int e2, input logic [3:0] t, output bit fired);
      in_valid = v;
      d1 = a;
      d2 = b;
      in_tag = t;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      #1;
      fired = v && rdy1;
      if (fired) begin
         q1.push_back({12'd0, t, 16'(e1)});
         q2.push_back({12'd0, t, 16'(e2)});
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [14:0] a, input logic [22:0] b, input int e1, input int e2,
                       input logic [3:0] t);
      bit f;
      for (int n = 0; n < 200; n++) begin
         step(1'b1, a, b, e1, e2, t, f);
         if (f) begin
            in_valid = 1'b0;
            return;
         end
      end
      check("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bit f;
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 0, 0, '0, f);
   endtask

   always @(negedge clk) begin
      #2;
      if (rst) begin
         held = 1'b0;
      end else begin
         if (held) begin
            check("hold1", {ov1, 11'd0, ot1, 8'd0, od1}, hold1);
            check("hold2", {ov2, 11'd0, ot2, 4'd0, od2}, hold2);
         end
         if (ov1 && out_ready) begin
            if (q1.size() == 0) check("unexpected1", {ot1, 8'd0, od1}, -1);
            else check("out1", {ot1, 8'd0, od1}, q1.pop_front());
         end
         if (ov2 && out_ready) begin
            if (q2.size() == 0) check("unexpected2", {ot2, 4'd0, od2}, -1);
            else check("out2", {ot2, 4'd0, od2}, q2.pop_front());
         end
         held = (ov1 || ov2) && !out_ready;
         hold1 = {ov1, 11'd0, ot1, 8'd0, od1};
         hold2 = {ov2, 11'd0, ot2, 4'd0, od2};
      end
   end

   initial begin
      logic [22:0] b;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", ov1, 0);
      check("rst_out_data", od1, 0);
      check("rst_out_tag", ot1, 0);
      check("rst_in_ready", rdy1, 1);
      check("rst_out_valid2", ov2, 0);
      @(negedge clk);
      // exact three-cycle latency
      send(15'd1000, 23'd1000, 156, 1000, 4'hA);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("latency", ov1, i == 2);
         @(negedge clk);
      end
      idle(2);
      // directed back-to-back vectors
      send(15'd0, 23'd8388607, 0, 2856, 4'h1);
      send(15'd211, 23'd3329, 0, 0, 4'h2);
      send(15'd1000, 23'd6663, 156, 5, 4'h3);
      send(15'd32767, 23'd3328, 62, 3328, 4'h4);
      idle(6);
      // stall with three in flight
      send(15'd422, 23'd3330, 0, 1, 4'h5);
      send(15'd500, 23'd10000, 78, 13, 4'h6);
      send(15'd32766, 23'd8388606, 61, 2855, 4'h7);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         #1;
         check("stall_in_ready", rdy1, 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      idle(6);
      check("drain_stall", q1.size() + q2.size(), 0);
      // reset with three in flight
      send(15'd1, 23'd2, 1, 2, 4'h8);
      send(15'd3, 23'd4, 3, 4, 4'h9);
      send(15'd5, 23'd6, 5, 6, 4'hB);
      rst = 1'b1;
      q1.delete();
      q2.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_out_valid", ov1, 0);
      check("midrst_out_data", od1, 0);
      check("midrst_out_tag", ot1, 0);
      check("midrst_out_valid2", ov2, 0);
      @(negedge clk);
      idle(8);
      // exhaustive sweep for Q=211, random operands for Q=3329
      for (int a = 0; a < 32768; a++) begin
         b = 23'($urandom_range(0, 8388607));
         send(15'(a), b, a % 211, int'(b) % 3329, 4'(a));
      end
      idle(6);
      // random valid/ready toggling
      rand_ready = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         idle($urandom_range(0, 1));
         b = 23'($urandom_range(0, 8388607));
         d1 = 15'($urandom_range(0, 32767));
         send(d1, b, int'(d1) % 211, int'(b) % 3329, 4'($urandom_range(0, 15)));
      end
      rand_ready = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 200 && (q1.size() + q2.size()) != 0; n++) idle(1);
      check("final_drain", q1.size() + q2.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
